turn_timer_sched: RTL
=====================

Name: turn_timer_sched

Overview:
Turn scheduler for the two-player memory game. Owns the shared 1 ms timer and grants it to one player at a time. Re-arms the timer between turns and shrinks the turn limit each round. Resolves each turn as a success, a mismatch or a timeout, and declares the winner or a draw. Sits between the input/match logic and the Timer1ms instance.

Parameters:
TW, 21, timer count width; matches the Timer1ms T output.
BASE_MS, 5000, turn limit in round 0, in ms.
STEP_MS, 500, limit reduction per completed round.
MIN_MS, 1000, floor on the turn limit.
MAX_ROUNDS, 8, number of completed rounds that ends the game as a draw.

Ports:
Clk  in  1  system clock; one clock domain.
Rst  in  1  asynchronous, active-high reset.
Start_Game  in  1  level; sampled only in IDLE or OVER.
P1_Done  in  1  one-cycle pulse: player 1 submitted a sequence.
P2_Done  in  1  one-cycle pulse: player 2 submitted a sequence.
Match  in  1  valid with a Done pulse; 1 = sequence correct.
Tmr_T  in  TW  elapsed ms from the timer.
Tmr_Start  out  1  timer enable. 1 = timer counts; 0 = timer clears to 0.
Turn  out  2  01 = P1 active, 10 = P2 active, 00 = none.
Round  out  4  completed rounds.
Time_Left  out  TW  ms remaining in the current turn; 0 outside a turn.
Timeout  out  1  one-cycle pulse when the active player's turn expires.
Game_Over  out  1  level; high in OVER.
Winner  out  2  00 = none, 01 = P1, 10 = P2, 11 = draw.

Behaviour:
- Reset (async, immediate): state IDLE, Tmr_Start=0, Turn=00, Round=0, Time_Left=0, Timeout=0, Game_Over=0, Winner=00.
- All outputs are registered.
- States: IDLE, P1_ARM, P1_RUN, P2_ARM, P2_RUN, OVER.
- IDLE: Start_Game=1 -> P1_ARM.
- OVER: Start_Game=1 -> P1_ARM. Round and Winner are cleared on this transition.
- ARM states:
  - Last exactly one cycle with Tmr_Start=0, so the timer is cleared.
  - Load Limit = max(BASE_MS - Round*STEP_MS, MIN_MS). Compute in TW+4 bits; the subtraction saturates at 0 before the max is applied.
  - Move to the matching RUN state.
- RUN states:
  - Tmr_Start=1; Turn shows the active player.
  - Time_Left = Limit - Tmr_T, saturating at 0.
  - Priority order, evaluated each cycle:
    1. Active player's Done with Match=1 = success.
    2. Active player's Done with Match=0 = fail.
    3. Tmr_T >= Limit = timeout.
  - Success in P1_RUN -> P2_ARM.
  - Success in P2_RUN: Round+1. If the new Round equals MAX_ROUNDS -> OVER with Winner=11; else -> P1_ARM.
  - Fail -> OVER; Winner = the other player.
  - Timeout -> pulse Timeout for 1 cycle, then OVER; Winner = the other player.
  - A Done pulse and timeout in the same cycle: the Done pulse wins.
- The non-active player's Done is ignored. Both Done pulses in one cycle: only the active player's is used.
- Start_Game is ignored in ARM and RUN states.
- On entry to OVER: Tmr_Start=0, Turn=00, Time_Left=0, Game_Over=1.
- Latency: Done pulse at edge N -> Turn changes at edge N+1, and the other player's timer starts at edge N+2 (one ARM cycle in between).
- Reset asserted mid-turn: immediate return to IDLE; Tmr_Start drops asynchronously.

Decomposition:
- Shared package game_pkg holds:
  - the state encoding;
  - Turn/Winner codes (TURN_NONE/P1/P2, WIN_NONE/P1/P2/DRAW);
  - the default timing constants.
- One sub-module, turn_limit_calc: combinational Limit from Round with saturating subtract and floor. Keeps the arithmetic testable on its own.

Test Plan (BASE_MS=10, STEP_MS=3, MIN_MS=4, MAX_ROUNDS=2; timer model adds 1 per cycle):
1. Reset, Start_Game=1 -> P1_ARM for 1 cycle with Tmr_Start=0, then Turn=01, Time_Left=10 counting down.
2. P1_Done+Match=1 at Tmr_T=3 -> next cycle Turn=10 with Tmr_Start=0; timer restarts at 0. P2_Done+Match=1 -> Round=1; the new P1 limit is 7.
3. Round=1, P1 idle until Tmr_T=7 -> Timeout pulse for 1 cycle; Game_Over=1, Winner=10, Tmr_Start=0.
4. P2 turn, P2_Done with Match=0 -> Winner=01. P1_Done pulses during P2's turn change nothing.
5. Two full successful rounds -> Round=2, Winner=11, Game_Over=1. Round-2 limit must clamp to 4, checked with MAX_ROUNDS=3.
6. Done+Match=1 in the same cycle Tmr_T reaches Limit -> success, no Timeout. Rst pulse mid-turn -> all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, turn/winner codes and default timing
// constants for the two-player memory game turn logic.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_P1_ARM = 3'd1,
    ST_P1_RUN = 3'd2,
    ST_P2_ARM = 3'd3,
    ST_P2_RUN = 3'd4,
    ST_OVER   = 3'd5
  } state_t;

  localparam logic [1:0] TURN_NONE = 2'b00;
  localparam logic [1:0] TURN_P1   = 2'b01;
  localparam logic [1:0] TURN_P2   = 2'b10;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_P1    = 2'b01;
  localparam logic [1:0] WIN_P2    = 2'b10;
  localparam logic [1:0] WIN_DRAW  = 2'b11;

  // Round counter width; holds up to 15 completed rounds.
  localparam int RND_W = 4;

  localparam int DEF_TW         = 21;
  localparam int DEF_BASE_MS    = 5000;
  localparam int DEF_STEP_MS    = 500;
  localparam int DEF_MIN_MS     = 1000;
  localparam int DEF_MAX_ROUNDS = 8;

endpackage

// File: rtl/turn_limit_calc.sv
// turn_limit_calc: turn limit for a given round count.
// Limit = max(BASE_MS - round*STEP_MS, MIN_MS), with the subtraction
// clamped at zero. Worked in TW+4 bits so round*STEP_MS cannot wrap.
module turn_limit_calc import game_pkg::*; #(
  parameter int TW      = DEF_TW,
  parameter int BASE_MS = DEF_BASE_MS,
  parameter int STEP_MS = DEF_STEP_MS,
  parameter int MIN_MS  = DEF_MIN_MS
) (
  input  logic [RND_W-1:0] round,
  output logic [TW-1:0]    limit
);

  localparam int CW = TW + 4;
  localparam logic [CW-1:0] BASE_C = CW'(BASE_MS);
  localparam logic [CW-1:0] STEP_C = CW'(STEP_MS);
  localparam logic [CW-1:0] MIN_C  = CW'(MIN_MS);

  logic [CW-1:0] dec;
  logic [CW-1:0] diff;
  logic [CW-1:0] floored;

  // Shrink the base limit by completed rounds, saturate at 0, then apply the floor
  always_comb begin
    dec     = CW'(round) * STEP_C;
    diff    = (dec >= BASE_C) ? '0 : (BASE_C - dec);
    floored = (diff < MIN_C) ? MIN_C : diff;
    limit   = TW'(floored);
  end

endmodule

// File: rtl/turn_timer_sched.sv
// turn_timer_sched: owns the shared 1 ms timer and hands it to one player at
// a time. Each turn is preceded by a one-cycle ARM state with the timer held
// in clear, then a RUN state where the turn resolves as success, mismatch or
// timeout. All outputs are registered and reflect the state being entered.
module turn_timer_sched import game_pkg::*; #(
  parameter int TW         = DEF_TW,
  parameter int BASE_MS    = DEF_BASE_MS,
  parameter int STEP_MS    = DEF_STEP_MS,
  parameter int MIN_MS     = DEF_MIN_MS,
  parameter int MAX_ROUNDS = DEF_MAX_ROUNDS
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start_Game,
  input  logic             P1_Done,
  input  logic             P2_Done,
  input  logic             Match,
  input  logic [TW-1:0]    Tmr_T,
  output logic             Tmr_Start,
  output logic [1:0]       Turn,
  output logic [RND_W-1:0] Round,
  output logic [TW-1:0]    Time_Left,
  output logic             Timeout,
  output logic             Game_Over,
  output logic [1:0]       Winner
);

  state_t state, state_nxt;

  logic [TW-1:0]    limit, limit_nxt, limit_calc;
  logic [RND_W-1:0] round_nxt;
  logic             tmr_start_nxt;
  logic [1:0]       turn_nxt;
  logic [TW-1:0]    time_left_nxt;
  logic             timeout_nxt;
  logic             game_over_nxt;
  logic [1:0]       winner_nxt;

  logic             act_done;
  logic             expired;
  logic [TW-1:0]    remain;
  logic [1:0]       other_win;

  turn_limit_calc #(
    .TW      (TW),
    .BASE_MS (BASE_MS),
    .STEP_MS (STEP_MS),
    .MIN_MS  (MIN_MS)
  ) u_limit (
    .round (Round),
    .limit (limit_calc)
  );

  // Next state plus next value of every registered output
  always_comb begin
    state_nxt     = state;
    limit_nxt     = limit;
    round_nxt     = Round;
    winner_nxt    = Winner;
    tmr_start_nxt = 1'b0;
    turn_nxt      = TURN_NONE;
    time_left_nxt = '0;
    timeout_nxt   = 1'b0;
    game_over_nxt = 1'b0;
    act_done      = 1'b0;
    other_win     = WIN_NONE;
    expired       = (Tmr_T >= limit);
    remain        = expired ? '0 : (limit - Tmr_T);

    case (state)
      ST_IDLE: begin
        if (Start_Game) state_nxt = ST_P1_ARM;
      end
      ST_OVER: begin
        if (Start_Game) begin
          state_nxt  = ST_P1_ARM;
          round_nxt  = '0;
          winner_nxt = WIN_NONE;
        end
      end
      ST_P1_ARM: begin
        limit_nxt = limit_calc;
        state_nxt = ST_P1_RUN;
      end
      ST_P2_ARM: begin
        limit_nxt = limit_calc;
        state_nxt = ST_P2_RUN;
      end
      ST_P1_RUN, ST_P2_RUN: begin
        // Only the active player's Done counts; the other one is dropped.
        act_done  = (state == ST_P1_RUN) ? P1_Done : P2_Done;
        other_win = (state == ST_P1_RUN) ? WIN_P2 : WIN_P1;
        if (act_done && Match) begin
          if (state == ST_P1_RUN) begin
            state_nxt = ST_P2_ARM;
          end else begin
            round_nxt = Round + 1'b1;
            if (round_nxt == RND_W'(MAX_ROUNDS)) begin
              state_nxt  = ST_OVER;
              winner_nxt = WIN_DRAW;
            end else begin
              state_nxt = ST_P1_ARM;
            end
          end
        end else if (act_done) begin
          state_nxt  = ST_OVER;
          winner_nxt = other_win;
        end else if (expired) begin
          // A Done in the same cycle takes the branches above, so a late
          // but correct submission still counts as success.
          state_nxt   = ST_OVER;
          winner_nxt  = other_win;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they line up with it.
    // Time_Left is registered, so within a turn it reflects the timer value
    // of the previous cycle; on entry it is loaded with the full limit.
    case (state_nxt)
      ST_P1_ARM: turn_nxt = TURN_P1;
      ST_P2_ARM: turn_nxt = TURN_P2;
      ST_P1_RUN: begin
        turn_nxt      = TURN_P1;
        tmr_start_nxt = 1'b1;
        time_left_nxt = (state == ST_P1_ARM) ? limit_nxt : remain;
      end
      ST_P2_RUN: begin
        turn_nxt      = TURN_P2;
        tmr_start_nxt = 1'b1;
        time_left_nxt = (state == ST_P2_ARM) ? limit_nxt : remain;
      end
      ST_OVER: game_over_nxt = 1'b1;
      default: ;
    endcase
  end

  // State and output registers; reset drops the timer enable immediately
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_IDLE;
      limit     <= '0;
      Tmr_Start <= 1'b0;
      Turn      <= TURN_NONE;
      Round     <= '0;
      Time_Left <= '0;
      Timeout   <= 1'b0;
      Game_Over <= 1'b0;
      Winner    <= WIN_NONE;
    end else begin
      state     <= state_nxt;
      limit     <= limit_nxt;
      Tmr_Start <= tmr_start_nxt;
      Turn      <= turn_nxt;
      Round     <= round_nxt;
      Time_Left <= time_left_nxt;
      Timeout   <= timeout_nxt;
      Game_Over <= game_over_nxt;
      Winner    <= winner_nxt;
    end
  end

endmodule
